// File: rtl/snitch_regfile_sb_if.sv
// Bundle of read, write, issue and scoreboard signals between the issue stage,
// the writeback arbiters and the register file.
interface snitch_regfile_sb_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 3,
  parameter int unsigned NR_WRITE_PORTS = 2
);
  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NR_READ_PORTS-1:0]                  rbusy_o;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NR_WRITE_PORTS-1:0]                 we_i;
  logic                                      wconflict_o;
  logic                                      issue_valid_i;
  logic [ADDR_WIDTH-1:0]                     issue_addr_i;
  logic                                      issue_ready_o;
  logic [NUM_WORDS-1:0]                      busy_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, issue_valid_i, issue_addr_i,
    input  rdata_o, rbusy_o, wconflict_o, issue_ready_o, busy_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, issue_valid_i, issue_addr_i,
    output rdata_o, rbusy_o, wconflict_o, issue_ready_o, busy_o
  );
endinterface

// File: rtl/snitch_regfile_sb.sv
// Flip-flop register file with multiple prioritised write ports, optional
// write-to-read bypass and a per-register busy scoreboard for hazard stalls.
module snitch_regfile_sb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 3,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter bit          BYPASS         = 1'b1
) (
  input logic               clk_i,
  input logic               rst_i,
  snitch_regfile_sb_if.slave bus
);
  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]                    mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]                     busy_q;
  logic [NUM_WORDS-1:0]                     clr;
  logic [NUM_WORDS-1:0]                     set;
  logic [NR_WRITE_PORTS-1:0]                wr_valid;
  logic                                     conflict;
  logic                                     issue_ready;
  logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NR_READ_PORTS-1:0]                 rbusy;

  // A write only counts if it targets a writable register.
  always_comb begin
    wr_valid = '0;
    clr      = '0;
    for (int unsigned i = 0; i < NR_WRITE_PORTS; i++) begin
      wr_valid[i] = bus.we_i[i] && !(ZERO_REG_ZERO && bus.waddr_i[i] == '0);
      if (wr_valid[i]) clr[bus.waddr_i[i]] = 1'b1;
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < NR_WRITE_PORTS; i++)
      for (int unsigned j = i + 1; j < NR_WRITE_PORTS; j++)
        if (wr_valid[i] && wr_valid[j] && bus.waddr_i[i] == bus.waddr_i[j])
          conflict = 1'b1;
  end

  assign issue_ready = (ZERO_REG_ZERO && bus.issue_addr_i == '0)
                     || !busy_q[bus.issue_addr_i] || clr[bus.issue_addr_i];

  always_comb begin
    set = '0;
    if (bus.issue_valid_i && issue_ready && !(ZERO_REG_ZERO && bus.issue_addr_i == '0))
      set[bus.issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= set | (busy_q & ~clr);
  end

  // Ports are visited in ascending order so the highest enabled index lands last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned a = 0; a < NUM_WORDS; a++) mem[a] <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_WRITE_PORTS; i++)
        if (wr_valid[i]) mem[bus.waddr_i[i]] <= bus.wdata_i[i];
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      rdata[r] = mem[bus.raddr_i[r]];
      if (BYPASS)
        for (int unsigned i = 0; i < NR_WRITE_PORTS; i++)
          if (wr_valid[i] && bus.waddr_i[i] == bus.raddr_i[r]) rdata[r] = bus.wdata_i[i];
      if (ZERO_REG_ZERO && bus.raddr_i[r] == '0) rdata[r] = '0;
      rbusy[r] = busy_q[bus.raddr_i[r]];
    end
  end

  assign bus.rdata_o       = rdata;
  assign bus.rbusy_o       = rbusy;
  assign bus.wconflict_o   = conflict;
  assign bus.issue_ready_o = issue_ready;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_snitch_regfile_sb.sv
// Random and directed stimulus for snitch_regfile_sb against an array-based
// reference model; a second instance without bypass checks same-cycle reads.
module tb_snitch_regfile_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0][4:0] raddr;
  logic [1:0][4:0] waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]      we;
  logic            iv;
  logic [4:0]      ia;

  logic [31:0] ref_mem [32];
  bit          ref_busy [32];
  int errs = 0;
  int checks = 0;

  snitch_regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(3), .NR_WRITE_PORTS(2)) bus_b ();
  snitch_regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(3), .NR_WRITE_PORTS(2)) bus_nb ();

  assign bus_b.raddr_i        = raddr;
  assign bus_b.waddr_i        = waddr;
  assign bus_b.wdata_i        = wdata;
  assign bus_b.we_i           = we;
  assign bus_b.issue_valid_i  = iv;
  assign bus_b.issue_addr_i   = ia;
  assign bus_nb.raddr_i       = raddr;
  assign bus_nb.waddr_i       = waddr;
  assign bus_nb.wdata_i       = wdata;
  assign bus_nb.we_i          = we;
  assign bus_nb.issue_valid_i = iv;
  assign bus_nb.issue_addr_i  = ia;

  snitch_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(3), .NR_WRITE_PORTS(2),
                      .ZERO_REG_ZERO(1'b1), .BYPASS(1'b1))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  snitch_regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(3), .NR_WRITE_PORTS(2),
                      .ZERO_REG_ZERO(1'b1), .BYPASS(1'b0))
    dut_nb (.clk_i(clk), .rst_i(rst), .bus(bus_nb));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Index of the port whose write to a survives this cycle, or -1.
  function automatic int winner(input logic [4:0] a);
    int w = -1;
    for (int i = 0; i < 2; i++)
      if (we[i] && waddr[i] == a && a != 5'd0) w = i;
    return w;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    int w = winner(a);
    if (a == 5'd0) return 32'd0;
    if (byp && w >= 0) return wdata[w];
    return ref_mem[a];
  endfunction

  function automatic bit exp_conflict();
    for (int a = 1; a < 32; a++) begin
      int n = 0;
      for (int i = 0; i < 2; i++)
        if (we[i] && waddr[i] == 5'(a)) n++;
      if (n >= 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_ready();
    return ia == 5'd0 || !ref_busy[ia] || winner(ia) >= 0;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] v;
    for (int a = 0; a < 32; a++) v[a] = ref_busy[a];
    return v;
  endfunction

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("wconflict", 64'(bus_b.wconflict_o), 64'(exp_conflict()));
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        chk($sformatf("rdata%0d", r), 64'(bus_b.rdata_o[r]), 64'(exp_rd(raddr[r], 1'b1)));
        chk($sformatf("rdata_nb%0d", r), 64'(bus_nb.rdata_o[r]), 64'(exp_rd(raddr[r], 1'b0)));
        chk($sformatf("rbusy%0d", r), 64'(bus_b.rbusy_o[r]), 64'(ref_busy[raddr[r]]));
      end
      chk("issue_ready", 64'(bus_b.issue_ready_o), 64'(exp_ready()));
      chk("busy_o", 64'(bus_b.busy_o), 64'(exp_busy()));
    end
  endtask

  task automatic advance();
    bit rdy;
    @(posedge clk);
    rdy = exp_ready();
    for (int a = 0; a < 32; a++) begin
      int w = winner(5'(a));
      if (rst) begin
        ref_mem[a]  = 32'd0;
        ref_busy[a] = 1'b0;
      end else begin
        if (w >= 0) ref_mem[a] = wdata[w];
        ref_busy[a] = (iv && rdy && ia == 5'(a) && a != 0) || (ref_busy[a] && w < 0);
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    check_model();
    advance();
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; iv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0; iv = 1'b0; ia = '0;
    step();
    step();

    // fill every register, mark x3 busy, then reset
    idle();
    for (int a = 1; a < 32; a++) begin
      we = 2'b01; waddr[0] = 5'(a); wdata[0] = $urandom;
      raddr[0] = 5'(a); raddr[1] = 5'($urandom_range(0, 31)); raddr[2] = 5'(a - 1);
      step();
    end
    idle(); iv = 1'b1; ia = 5'd3;
    step();
    idle(); rst = 1'b1;
    step();
    idle();
    for (int a = 0; a < 32; a += 3) begin
      for (int r = 0; r < 3; r++) raddr[r] = 5'((a + r) % 32);
      ia = 5'(a);
      settle();
      check_model();
      for (int r = 0; r < 3; r++) chk("reset_rdata", 64'(bus_b.rdata_o[r]), 64'd0);
      chk("reset_busy", 64'(bus_b.busy_o), 64'd0);
      chk("reset_ready", 64'(bus_b.issue_ready_o), 64'd1);
      advance();
    end

    // write conflict on x5
    idle(); we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'hAAAA_0000; wdata[1] = 32'h5555_1111;
    settle(); check_model(); chk("conflict", 64'(bus_b.wconflict_o), 64'd1); advance();
    idle(); raddr = {5'd5, 5'd5, 5'd5};
    settle(); check_model(); chk("conflict_win", 64'(bus_b.rdata_o[0]), 64'h5555_1111); advance();

    // bypass on x7
    idle(); we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h1234_5678;
    step();
    we = 2'b01; wdata[0] = 32'hDEAD_BEEF; raddr = {5'd7, 5'd7, 5'd7};
    settle(); check_model();
    for (int r = 0; r < 3; r++) chk("bypass", 64'(bus_b.rdata_o[r]), 64'hDEAD_BEEF);
    chk("nobypass_old", 64'(bus_nb.rdata_o[0]), 64'h1234_5678);
    advance();
    idle();
    settle(); check_model(); chk("nobypass_new", 64'(bus_nb.rdata_o[1]), 64'hDEAD_BEEF); advance();

    // zero register
    idle(); we = 2'b11; waddr = '0; wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    iv = 1'b1; ia = 5'd0; raddr = '0;
    settle(); check_model();
    chk("x0_conflict", 64'(bus_b.wconflict_o), 64'd0);
    chk("x0_rdata", 64'(bus_b.rdata_o[2]), 64'd0);
    chk("x0_ready", 64'(bus_b.issue_ready_o), 64'd1);
    advance();
    idle();
    settle(); check_model();
    chk("x0_busy", 64'(bus_b.busy_o[0]), 64'd0);
    chk("x0_rdata_after", 64'(bus_b.rdata_o[0]), 64'd0);
    advance();

    // RAW/WAW on x3
    idle(); iv = 1'b1; ia = 5'd3; raddr[0] = 5'd3;
    step();
    settle(); check_model();
    chk("raw_rbusy", 64'(bus_b.rbusy_o[0]), 64'd1);
    chk("waw_stall", 64'(bus_b.issue_ready_o), 64'd0);
    advance();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h0000_0333;
    settle(); check_model();
    chk("wb_release", 64'(bus_b.issue_ready_o), 64'd1);
    chk("rbusy_not_bypassed", 64'(bus_b.rbusy_o[0]), 64'd1);
    advance();
    idle();
    settle(); check_model(); chk("set_wins", 64'(bus_b.busy_o[3]), 64'd1); advance();

    // reset mid-operation on x9
    idle(); rst = 1'b1; we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hCAFE_0009;
    iv = 1'b1; ia = 5'd9;
    step();
    idle(); raddr[0] = 5'd9;
    settle(); check_model();
    chk("midrst_rdata", 64'(bus_b.rdata_o[0]), 64'd0);
    chk("midrst_busy", 64'(bus_b.busy_o[9]), 64'd0);
    advance();

    // random traffic, addresses often clustered to provoke hazards
    for (int n = 0; n < 600; n++) begin
      int span = ($urandom_range(0, 3) == 0) ? 31 : 7;
      rst = ($urandom_range(0, 63) == 0);
      we  = 2'($urandom);
      iv  = 1'($urandom);
      ia  = 5'($urandom_range(0, span));
      for (int i = 0; i < 2; i++) begin
        waddr[i] = 5'($urandom_range(0, span));
        wdata[i] = $urandom;
      end
      for (int r = 0; r < 3; r++) raddr[r] = 5'($urandom_range(0, span));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
